instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Sequential RV32I instruction encoder and loader. It is the inverse of `Control_Unit`: where that block decodes opcode/funct fields into control signals, this block takes symbolic instruction descriptors over a valid/ready stream and packs them into 32-bit machine words. It writes each word to consecutive instruction-memory addresses, filling the single-cycle core's program store before release. Immediate range violations and illegal kinds are detected, and loading stops with an error index.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width.
- `DEPTH`, default 256: maximum words written per load (≤ 2^ADDR_W).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a load; honored only in IDLE, DONE or ERR.
- `in_valid` input 1: descriptor valid.
- `in_ready` output 1: descriptor accepted when `in_valid && in_ready`.
- `in_kind` input 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 ADDI, 6 SRAI, 7 LW, 8 SW, 9 BEQ, 10 BGE, 11 JAL, 12 LUI; 13–15 illegal.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register fields.
- `in_imm` input 32: signed byte offset or immediate value. For LUI it is the full 32-bit value; for SRAI it is the shamt.
- `in_last` input 1: final descriptor of the program.
- `imem_we` output 1: write strobe.
- `imem_addr` output ADDR_W: word address.
- `imem_wdata` output 32: encoded instruction.
- `busy` output 1: state is RUN.
- `done` output 1: level, held in DONE.
- `full` output 1: `count == DEPTH` while in RUN.
- `err` output 1: level, held in ERR.
- `err_index` output ADDR_W: count value at the rejected descriptor.
- `count` output ADDR_W+1: words written in the current load.

## Operation
- States: IDLE → (start) RUN → (last word written) DONE, or RUN → (bad descriptor) ERR.
- From DONE or ERR, `start` goes to RUN. Asserting `start` in RUN has no effect.
- On entry to RUN, `count`, `err_index` and the address counter are cleared to 0.
- `in_ready = (state == RUN) && !full && !last_pending`.
- Encoding rules:
  - R-type: opcode 0110011. funct3 is ADD/SUB 000, AND 111, OR 110, SLT 010. funct7 is 0100000 for SUB, otherwise 0.
  - ADDI: opcode 0010011, funct3 000.
  - SRAI: opcode 0010011, funct3 101, imm[11:5] = 0100000.
  - LW: opcode 0000011, funct3 010.
  - SW: opcode 0100011, funct3 010.
  - BEQ and BGE: opcode 1100011, funct3 000 and 101 respectively.
  - JAL: opcode 1101111.
  - LUI: opcode 0110111, `imem_wdata[31:12] = in_imm[31:12]`.
- Range checks; any failure or an illegal kind raises an error:
  - I/S immediates must lie in −2048..2047.
  - SRAI shamt must be 0..31.
  - B immediates must be even and in −4096..4094.
  - J immediates must be even and in −2^20..2^20−2.
  - LUI requires `in_imm[11:0] == 0`.
- On error:
  - The offending word is not written.
  - `err_index` takes the value of `count`.
  - State goes to ERR and `in_ready` drops the next cycle.
  - Earlier words remain in memory.
- Full: when `count` reaches DEPTH, `in_ready` stays low and the block stalls in RUN until `start` or reset. `start` in RUN is ignored, so only reset exits the stall.
- `rd`/`rs` fields are unused by some kinds and are encoded into their field positions only where the format has them.

## Timing
- Reset value: all outputs 0 and state IDLE, immediately and asynchronously on `rst_n` low.
- Latency: a descriptor accepted at edge N produces `imem_we = 1` with registered address and data for the cycle after edge N. `count` increments at edge N+1.
- Throughput: one word per cycle under continuous `in_valid`.
- `in_last` accepted at edge N:
  - `in_ready` is low from edge N.
  - The write occurs in cycle N→N+1.
  - DONE is entered at edge N+1, so `done` is high from edge N+1.
- An error at edge N sets `err` from edge N and produces no write.
- Reset mid-load: the in-flight write is squashed and the memory contents already written are left as-is.
- `imem_addr` wraps modulo 2^ADDR_W only if DEPTH = 2^ADDR_W. `full` prevents further writes.

## Structure
- Shared package `riscv_isa_pkg` holds:
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI);
  - funct3/funct7 constants;
  - the 4-bit `instr_kind_t` enum.
- `Control_Unit` reuses the same opcode constants.
- One sub-module, `instr_field_packer`: purely combinational. It takes the descriptor and outputs `word[31:0]` and `bad`. The top level holds the FSM, counters and output registers.

## Test plan
- start; ADDI rd=1 rs1=0 imm=5 with last -> write at addr 0 of 0x00500093; `done` high next cycle; `count` = 1.
- Back-to-back stream SUB x3,x1,x2; SW x2,8(x1); BEQ x1,x2,−4 (last) -> consecutive cycles write 0x402081B3, 0x0020A423, 0xFE208EE3 at addr 0..2.
- JAL rd=1 imm=8, then LUI rd=5 imm=0x12345000 (last) -> writes 0x008000EF, 0x123452B7.
- ADD, then ADDI imm=2048 -> only addr 0 written; `err` = 1; `err_index` = 1; `in_ready` = 0; `start` restarts with `count` = 0.
- DEPTH=4 with 5 descriptors and no last -> 4 writes, `full` = 1, `in_ready` stuck low, 5th not accepted.
- `rst_n` pulsed low mid-stream -> all outputs 0 asynchronously, state IDLE, no `imem_we` after release until `start`.

Source files
------------

// File: rtl/riscv_isa_pkg.sv
// RV32I opcode/funct constants and the descriptor kind enum shared by the
// instruction loader and Control_Unit.
package riscv_isa_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SRA     = 3'b101;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BGE     = 3'b101;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    K_ADD  = 4'd0,
    K_SUB  = 4'd1,
    K_AND  = 4'd2,
    K_OR   = 4'd3,
    K_SLT  = 4'd4,
    K_ADDI = 4'd5,
    K_SRAI = 4'd6,
    K_LW   = 4'd7,
    K_SW   = 4'd8,
    K_BEQ  = 4'd9,
    K_BGE  = 4'd10,
    K_JAL  = 4'd11,
    K_LUI  = 4'd12
  } instr_kind_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } ldr_state_t;

  function automatic logic in_range(input logic [31:0] v, input int lo, input int hi);
    return ($signed(v) >= lo) && ($signed(v) <= hi);
  endfunction

endpackage

// File: rtl/instr_field_packer.sv
// Combinational RV32I field packer: descriptor in, machine word and
// range/kind violation flag out.
module instr_field_packer
  import riscv_isa_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        bad
);

  instr_kind_t k;
  assign k = instr_kind_t'(kind);

  always_comb begin
    word = 32'h0;
    bad  = 1'b0;
    case (k)
      K_ADD: word = {F7_ZERO, rs2, rs1, F3_ADD_SUB, rd, OP_R};
      K_SUB: word = {F7_ALT,  rs2, rs1, F3_ADD_SUB, rd, OP_R};
      K_AND: word = {F7_ZERO, rs2, rs1, F3_AND,     rd, OP_R};
      K_OR:  word = {F7_ZERO, rs2, rs1, F3_OR,      rd, OP_R};
      K_SLT: word = {F7_ZERO, rs2, rs1, F3_SLT,     rd, OP_R};
      K_ADDI: begin
        word = {imm[11:0], rs1, F3_ADD_SUB, rd, OP_I};
        bad  = !in_range(imm, -2048, 2047);
      end
      K_SRAI: begin
        word = {F7_ALT, imm[4:0], rs1, F3_SRA, rd, OP_I};
        bad  = (imm[31:5] != 27'h0);
      end
      K_LW: begin
        word = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
        bad  = !in_range(imm, -2048, 2047);
      end
      K_SW: begin
        word = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
        bad  = !in_range(imm, -2048, 2047);
      end
      K_BEQ: begin
        word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
        bad  = imm[0] || !in_range(imm, -4096, 4094);
      end
      K_BGE: begin
        word = {imm[12], imm[10:5], rs2, rs1, F3_BGE, imm[4:1], imm[11], OP_BRANCH};
        bad  = imm[0] || !in_range(imm, -4096, 4094);
      end
      K_JAL: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        bad  = imm[0] || !in_range(imm, -1048576, 1048574);
      end
      K_LUI: begin
        word = {imm[31:12], rd, OP_LUI};
        bad  = (imm[11:0] != 12'h0);
      end
      default: bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams symbolic descriptors into packed RV32I words written to
// consecutive instruction-memory addresses.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | accepting descriptors and writing words
//   DONE  | last word written, waiting for start
//   ERR   | bad descriptor rejected, waiting for start
module instr_encoder_loader
  import riscv_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W-1:0] err_index,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] CAP    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CAP_M1 = (ADDR_W+1)'(DEPTH - 1);

  ldr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              last_pending;
  logic [31:0]       word;
  logic              bad;
  logic              accept;
  logic              enter_run;
  logic              cap_pending;

  instr_field_packer u_packer (
    .kind (in_kind),
    .rd   (in_rd),
    .rs1  (in_rs1),
    .rs2  (in_rs2),
    .imm  (in_imm),
    .word (word),
    .bad  (bad)
  );

  // count lags acceptance by one cycle, so the in-flight word that will
  // make count reach DEPTH must also close the input.
  assign cap_pending = imem_we && (count == CAP_M1);
  assign full        = (state == S_RUN) && (count == CAP);
  assign in_ready    = (state == S_RUN) && !full && !last_pending && !cap_pending;
  assign accept      = in_valid && in_ready;
  assign busy        = (state == S_RUN);
  assign done        = (state == S_DONE);
  assign err         = (state == S_ERR);
  assign enter_run   = (state != S_RUN) && (state_nxt == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (accept && bad)     state_nxt = S_ERR;
        else if (last_pending) state_nxt = S_DONE;
      end
      S_DONE: if (start) state_nxt = S_RUN;
      S_ERR:  if (start) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      err_index    <= '0;
      addr_q       <= '0;
      last_pending <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'h0;
    end else if (enter_run) begin
      count        <= '0;
      err_index    <= '0;
      addr_q       <= '0;
      last_pending <= 1'b0;
      imem_we      <= 1'b0;
    end else begin
      count   <= count + (ADDR_W+1)'(imem_we);
      imem_we <= accept && !bad;
      if (last_pending) last_pending <= 1'b0;
      if (accept && !bad) begin
        imem_addr  <= addr_q;
        imem_wdata <= word;
        addr_q     <= addr_q + 1'b1;
        if (in_last) last_pending <= 1'b1;
      end
      // The index includes a word still being written this cycle.
      if (accept && bad) err_index <= count[ADDR_W-1:0] + ADDR_W'(imem_we);
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, in_last;
  logic [3:0]  in_kind;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, imem_we, busy, done, full, err;
  logic [7:0]  imem_addr, err_index;
  logic [31:0] imem_wdata;
  logic [8:0]  count;

  logic        s_start, s_valid;
  logic        s_ready, s_we, s_busy, s_done, s_full, s_err;
  logic [2:0]  s_addr, s_err_index;
  logic [31:0] s_wdata;
  logic [3:0]  s_count;

  int tests  = 0;
  int failed = 0;
  int writes;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .full(full), .err(err), .err_index(err_index), .count(count)
  );

  instr_encoder_loader #(.ADDR_W(3), .DEPTH(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid), .in_ready(s_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_last(in_last), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .busy(s_busy), .done(s_done), .full(s_full), .err(s_err), .err_index(s_err_index),
    .count(s_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic last);
    in_valid = 1'b1;
    in_kind  = k;
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_last  = last;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    s_start = 1'b0; s_valid = 1'b0;
    in_kind = 4'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 32'h0;
    #2;
    check("rst_we", imem_we, 1'b0);
    check("rst_state", {busy, done, err, full, in_ready}, 5'b0);
    check("rst_count", count, 9'd0);
    check("rst_data", imem_wdata, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    check("idle_ready", in_ready, 1'b0);

    // single ADDI with last
    start = 1'b1; tick(); start = 1'b0;
    check("t1_busy", busy, 1'b1);
    drive(4'd5, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    check("t1_ready", in_ready, 1'b1);
    tick(); in_valid = 1'b0;
    check("t1_we", imem_we, 1'b1);
    check("t1_addr", imem_addr, 8'd0);
    check("t1_data", imem_wdata, 32'h00500093);
    check("t1_ready_low", in_ready, 1'b0);
    check("t1_not_done", done, 1'b0);
    tick();
    check("t1_done", done, 1'b1);
    check("t1_count", count, 9'd1);
    check("t1_we_off", imem_we, 1'b0);

    // back-to-back SUB, SW, BEQ
    start = 1'b1; tick(); start = 1'b0;
    check("t2_count0", count, 9'd0);
    drive(4'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0); tick();
    check("t2_sub", {imem_we, imem_addr, imem_wdata}, {1'b1, 8'd0, 32'h402081B3});
    drive(4'd8, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0); tick();
    check("t2_sw", {imem_we, imem_addr, imem_wdata}, {1'b1, 8'd1, 32'h0020A423});
    check("t2_count1", count, 9'd1);
    drive(4'd9, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b1); tick(); in_valid = 1'b0;
    check("t2_beq", {imem_we, imem_addr, imem_wdata}, {1'b1, 8'd2, 32'hFE208EE3});
    tick();
    check("t2_done", {done, busy}, 2'b10);
    check("t2_count", count, 9'd3);

    // JAL, SRAI, LUI
    start = 1'b1; tick(); start = 1'b0;
    drive(4'd11, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0); tick();
    check("t3_jal", {imem_we, imem_addr, imem_wdata}, {1'b1, 8'd0, 32'h008000EF});
    drive(4'd6, 5'd1, 5'd2, 5'd0, 32'd31, 1'b0); tick();
    check("t3_srai", {imem_we, imem_addr, imem_wdata}, {1'b1, 8'd1, 32'h41F15093});
    drive(4'd12, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1); tick(); in_valid = 1'b0;
    check("t3_lui", {imem_we, imem_addr, imem_wdata}, {1'b1, 8'd2, 32'h123452B7});
    tick();
    check("t3_done", {done, count}, {1'b1, 9'd3});

    // ADD then out-of-range ADDI
    start = 1'b1; tick(); start = 1'b0;
    drive(4'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0); tick();
    check("t4_add", {imem_we, imem_addr}, {1'b1, 8'd0});
    drive(4'd5, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0); tick(); in_valid = 1'b0;
    check("t4_err", err, 1'b1);
    check("t4_no_write", imem_we, 1'b0);
    check("t4_err_index", err_index, 8'd1);
    check("t4_ready", in_ready, 1'b0);
    check("t4_count", count, 9'd1);
    tick();
    check("t4_err_held", {err, busy}, 2'b10);
    start = 1'b1; tick(); start = 1'b0;
    check("t4_restart", {busy, err, count, err_index}, {1'b1, 1'b0, 9'd0, 8'd0});

    // boundary immediates: -2048 accepted, odd branch offset rejected
    drive(4'd5, 5'd1, 5'd0, 5'd0, -32'sd2048, 1'b0); tick();
    check("t5_min_imm", {imem_we, imem_wdata}, {1'b1, 32'h80000093});
    drive(4'd10, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0); tick(); in_valid = 1'b0;
    check("t5_odd_branch", {err, imem_we, err_index}, {1'b1, 1'b0, 8'd1});

    // illegal kind right after restart
    start = 1'b1; tick(); start = 1'b0;
    drive(4'd13, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0); tick(); in_valid = 1'b0;
    check("t6_illegal", {err, imem_we, err_index}, {1'b1, 1'b0, 8'd0});

    // DEPTH=4 instance, 5+ descriptors offered without last
    s_start = 1'b1; tick(); s_start = 1'b0;
    drive(4'd5, 5'd2, 5'd0, 5'd0, 32'd7, 1'b0);
    in_valid = 1'b0;
    s_valid = 1'b1;
    writes = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (s_we) writes++;
    end
    check("t7_writes", writes, 4);
    check("t7_full", {s_full, s_ready, s_busy}, 3'b101);
    check("t7_count", s_count, 4'd4);
    check("t7_last_addr", s_addr, 3'd3);
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("t7_start_ignored", {s_full, s_count}, {1'b1, 4'd4});
    s_valid = 1'b0;

    // reset mid-stream
    start = 1'b1; tick(); start = 1'b0;
    drive(4'd5, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0); tick();
    check("t8_pre_we", imem_we, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t8_async_out", {imem_we, busy, done, err, full, in_ready}, 6'b0);
    check("t8_async_vals", {count, imem_addr, err_index, imem_wdata}, 57'h0);
    check("t8_small_rst", {s_full, s_busy, s_count}, 6'b0);
    tick();
    rst_n = 1'b1;
    writes = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (imem_we) writes++;
    end
    check("t8_no_write", writes, 0);
    check("t8_idle", {busy, in_ready}, 2'b00);
    in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
